bd_request_issuer: RTL

- Per-channel requester in front of the channel's BD buffer in the multi-channel PCIe DMA engine.
- Accepts BD fetch requests by BD index and compares them against the buffer's tag (`bd_buf_addr`) and entry valid mask.
- On a hit, issues a hit command to the buffer.
- On a miss, issues a miss command plus a 512-byte PCIe memory-read request for the whole 16-BD block, then waits for the BD to be delivered to the Response Queue.

---
 rtl/bd_request_issuer_if.sv | 39 +++
 rtl/bd_request_issuer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bd_request_issuer_if.sv
// Stream bundle between a channel's BD request issuer and its neighbours:
// the incoming BD fetch request, the buffer command strobe and the PCIe
// memory-read request toward the host.
interface bd_request_issuer_if;
  logic [26:0] s_axis_bd_req_tdata;
  logic        s_axis_bd_req_tvalid;
  logic        s_axis_bd_req_tready;

  logic [43:0] m_axis_buffer_cmd_tdata;
  logic        m_axis_buffer_cmd_tvalid;

  logic [79:0] m_axis_rd_req_tdata;
  logic        m_axis_rd_req_tvalid;
  logic        m_axis_rd_req_tready;

  // Issuer side: consumes requests, produces commands and read requests.
  modport master (
    input  s_axis_bd_req_tdata,
    input  s_axis_bd_req_tvalid,
    output s_axis_bd_req_tready,
    output m_axis_buffer_cmd_tdata,
    output m_axis_buffer_cmd_tvalid,
    output m_axis_rd_req_tdata,
    output m_axis_rd_req_tvalid,
    input  m_axis_rd_req_tready
  );

  // Environment side: produces requests, consumes commands and read requests.
  modport slave (
    output s_axis_bd_req_tdata,
    output s_axis_bd_req_tvalid,
    input  s_axis_bd_req_tready,
    input  m_axis_buffer_cmd_tdata,
    input  m_axis_buffer_cmd_tvalid,
    input  m_axis_rd_req_tdata,
    input  m_axis_rd_req_tvalid,
    output m_axis_rd_req_tready
  );
endinterface

// File: rtl/bd_request_issuer.sv
// Per-channel BD request issuer. Takes one BD fetch request at a time,
// checks it against the BD buffer's tag and valid mask, tells the buffer
// whether it is a hit or a miss, fetches the whole 16-BD block (512 bytes)
// from host memory on a miss, and then waits for the buffer to hand the BD
// to the response queue. A long wait raises a sticky timeout flag but the
// issuer keeps waiting.
module bd_request_issuer #(
  parameter int CHANNEL_ID     = 0,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                       user_clk,
  input  logic                       user_reset,
  bd_request_issuer_if.master        bus,
  input  logic [63:0]                ring_base_addr,
  input  logic [22:0]                bd_buf_addr,
  input  logic [15:0]                bd_buf_valid,
  input  logic                       bd_done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_CMD_HIT   = 3'd2;
  localparam logic [2:0] ST_CMD_MISS  = 3'd3;
  localparam logic [2:0] ST_RD_REQ    = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  localparam logic [31:0] TMO_LIMIT   = 32'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RD_TAG      = 4'(CHANNEL_ID);
  localparam logic [11:0] BLOCK_BYTES = 12'd512;

  logic [2:0]  state_q;
  logic [2:0]  state_d;

  logic [22:0] blk_q;
  logic [3:0]  off_q;

  logic        lookup_hit;
  logic        req_fire;
  logic        enter_wait;

  logic [43:0] cmd_tdata_q;
  logic        cmd_tvalid_q;
  logic [79:0] rd_tdata_q;
  logic        rd_tvalid_q;
  logic [63:0] block_host_addr;

  logic [31:0] tmo_cnt_q;

  assign req_fire   = bus.s_axis_bd_req_tvalid && (state_q == ST_IDLE);
  assign lookup_hit = (bd_buf_addr == blk_q) && bd_buf_valid[off_q];
  assign enter_wait = (state_d == ST_WAIT_DONE) && (state_q != ST_WAIT_DONE);

  // A block of 16 BDs is 512 bytes, so the block address shifted by 9 is
  // the byte offset of the block inside the ring; overflow simply wraps.
  assign block_host_addr = ring_base_addr + {32'd0, blk_q, 9'd0};

  assign bus.s_axis_bd_req_tready     = (state_q == ST_IDLE);
  assign bus.m_axis_buffer_cmd_tdata  = cmd_tdata_q;
  assign bus.m_axis_buffer_cmd_tvalid = cmd_tvalid_q;
  assign bus.m_axis_rd_req_tdata      = rd_tdata_q;
  assign bus.m_axis_rd_req_tvalid     = rd_tvalid_q;
  assign busy                         = (state_q != ST_IDLE);

  // Next-state selection; stray bd_done / rd_req_tready in other states fall through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_fire) state_d = ST_LOOKUP;
      ST_LOOKUP:    state_d = lookup_hit ? ST_CMD_HIT : ST_CMD_MISS;
      ST_CMD_HIT:   state_d = ST_WAIT_DONE;
      ST_CMD_MISS:  state_d = ST_RD_REQ;
      ST_RD_REQ:    if (bus.m_axis_rd_req_tready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bd_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture block address and entry offset of the accepted request.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      blk_q <= 23'd0;
      off_q <= 4'd0;
    end else if (req_fire) begin
      blk_q <= bus.s_axis_bd_req_tdata[26:4];
      off_q <= bus.s_axis_bd_req_tdata[3:0];
    end
  end

  // Buffer command: loaded at the end of LOOKUP so the strobe lines up with the CMD state.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      cmd_tvalid_q <= 1'b0;
      cmd_tdata_q  <= 44'd0;
    end else begin
      cmd_tvalid_q <= (state_q == ST_LOOKUP);
      if (state_q == ST_LOOKUP) begin
        cmd_tdata_q <= {blk_q, off_q, lookup_hit,
                        (lookup_hit ? 16'h0000 : 16'hFFFF)};
      end
    end
  end

  // Host read request: raised leaving CMD_MISS, held untouched until the handshake.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      rd_tvalid_q <= 1'b0;
      rd_tdata_q  <= 80'd0;
    end else if (state_q == ST_CMD_MISS) begin
      rd_tvalid_q <= 1'b1;
      rd_tdata_q  <= {block_host_addr, BLOCK_BYTES, RD_TAG};
    end else if ((state_q == ST_RD_REQ) && bus.m_axis_rd_req_tready) begin
      rd_tvalid_q <= 1'b0;
    end
  end

  // Saturating hit and miss statistics, bumped once per issued command.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else begin
      if ((state_q == ST_CMD_HIT) && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if ((state_q == ST_CMD_MISS) && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  // Wait timer: restarts on each entry to WAIT_DONE and parks at the limit.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      tmo_cnt_q <= 32'd0;
    end else if (enter_wait) begin
      tmo_cnt_q <= 32'd0;
    end else if ((state_q == ST_WAIT_DONE) && (tmo_cnt_q != TMO_LIMIT)) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  // Sticky timeout flag; only a reset clears it.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      timeout_err <= 1'b0;
    end else if ((state_q == ST_WAIT_DONE) && (tmo_cnt_q == TMO_LIMIT)) begin
      timeout_err <= 1'b1;
    end
  end

endmodule
